mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the 5-stage pipeline, directly downstream of the EX/MEM register.
//  Resolves branches from EX/MEM Branch/Zero and drives the data-memory req/ack port.
//  Stalls the front end until the memory transaction completes.
//  Produces the registered MEM/WB pipeline outputs consumed by write-back.
// PARAMETERS
//  TIMEOUT  16  max cycles BUSY waits for mem_ack_i before aborting (>=2)
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_i          in   1   reset, asynchronous, active-high
//  ALUResult_i    in   32  EX/MEM ALU result (address for loads/stores)
//  RS2data_i      in   32  EX/MEM store data
//  Zero_i         in   1   EX/MEM ALU zero flag
//  pc_branch_i    in   32  EX/MEM branch target
//  Branch_i       in   1   EX/MEM branch control
//  MemRead_i      in   1   EX/MEM load control
//  MemWrite_i     in   1   EX/MEM store control
//  MemtoReg_i     in   1   EX/MEM WB-select control
//  RegWrite_i     in   1   EX/MEM register-write control
//  RDaddr_i       in   5   EX/MEM destination register
//  mem_req_o      out  1   data-memory request
//  mem_we_o       out  1   1=write, 0=read; valid while mem_req_o=1
//  mem_addr_o     out  32  {ALUResult_i[31:2],2'b00}
//  mem_wdata_o    out  32  RS2data_i
//  mem_ack_i      in   1   memory completion; read data valid in the same cycle
//  mem_rdata_i    in   32  read data
//  stall_o        out  1   freeze PC, IF/ID, ID/EX, EX/MEM this cycle
//  pc_src_o       out  1   Branch_i & Zero_i (combinational)
//  pc_branch_o    out  32  pc_branch_i (combinational)
//  RegWrite_o     out  1   MEM/WB register-write
//  MemtoReg_o     out  1   MEM/WB WB-select
//  ALUResult_o    out  32  MEM/WB ALU result
//  ReadData_o     out  32  MEM/WB load data
//  RDaddr_o       out  5   MEM/WB destination register
//  err_o          out  1   sticky error flag; cleared only by reset
//  err_cause_o    out  2   01=misaligned, 10=timeout; first error wins
// BEHAVIOUR
//  - Reset: all registered outputs 0; state=IDLE; timeout counter 0; err_o=0; err_cause_o=0.
//  - mem_op = MemRead_i | MemWrite_i; a write takes priority if both are set.
//  - Misaligned: mem_op with ALUResult_i[1:0]!=0.
//    No request, no stall; the instruction retires with RegWrite_o=0 and ReadData_o=0.
//    Sets err_o and err_cause_o=01.
//  - IDLE: mem_req_o = aligned mem_op (combinational); mem_we_o=MemWrite_i.
//    If mem_ack_i is high in the same cycle, the access completes with zero wait and stall_o=0.
//    Otherwise stall_o=1 and the next state is BUSY with count=1.
//  - BUSY: mem_req_o=1 and stall_o=1. Inputs are held stable because EX/MEM is frozen.
//    On mem_ack_i: the access completes, stall_o=0 this cycle, next state IDLE.
//    On count==TIMEOUT-1 with no ack: abort. stall_o=0, ReadData_o=0, RegWrite_o=0.
//    The abort also sets err_o with err_cause_o=10, and the next state is IDLE.
//    Otherwise count increments.
//  - mem_ack_i while no request is outstanding is ignored.
//  - MEM/WB update happens on every rising edge:
//    - stall_o=0: capture RegWrite, MemtoReg, ALUResult, RDaddr; ReadData<=mem_rdata_i on a load, else holds.
//    - stall_o=1: insert a bubble (RegWrite_o=0, MemtoReg_o=0); other fields hold.
//  - Latency: a non-memory instruction reaches MEM/WB 1 cycle after it is present.
//    A load/store takes 1+N cycles, where N is the number of wait cycles before ack.
//  - pc_src_o/pc_branch_o are unaffected by stall. Branches never stall this stage.
//  - Reset asserted mid-transaction: mem_req_o drops immediately (async); the FSM returns to IDLE.
// TESTING
//  ALU op RegWrite=1 RDaddr=5 ALURes=0x1234 -> next cycle RegWrite_o=1, ALUResult_o=0x1234, stall_o=0.
//  Load addr 0x40, ack same cycle with rdata=0xCAFE -> no stall; ReadData_o=0xCAFE next edge.
//  Store addr 0x80 data 0xBEEF, ack after 3 cycles -> req/we held 4 cycles; stall 3 cycles, 3 bubbles.
//  Load with no ack, TIMEOUT=16 -> stall 15 cycles, then RegWrite_o=0, err_o=1, err_cause_o=10.
//  Load addr 0x42 -> no req, no stall, err_cause_o=01; a later timeout leaves the cause at 01.
//  Branch=1 Zero=1 target 0x100 -> pc_src_o=1, pc_branch_o=0x100 in the same cycle; rst_i mid-BUSY -> req_o=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: branch resolution, data-memory req/ack handshake with a
// timeout abort, alignment checking and the registered MEM/WB outputs.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] RS2data_i,
    input  logic        Zero_i,
    input  logic [31:0] pc_branch_i,
    input  logic        Branch_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        MemtoReg_i,
    input  logic        RegWrite_i,
    input  logic [4:0]  RDaddr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        pc_src_o,
    output logic [31:0] pc_branch_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] ALUResult_o,
    output logic [31:0] ReadData_o,
    output logic [4:0]  RDaddr_o,
    output logic        err_o,
    output logic [1:0]  err_cause_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          regWrite_q, memtoReg_q, err_q;
    logic [31:0]   aluResult_q, readData_q;
    logic [4:0]    rdAddr_q;
    logic [1:0]    errCause_q;

    logic memOp, isLoad, alignedOp, misaligned, complete, abort, stall;

    // A write wins when both controls are set, so only a pure read is a load.
    assign memOp      = MemRead_i | MemWrite_i;
    assign isLoad     = MemRead_i & ~MemWrite_i;
    assign alignedOp  = memOp & (ALUResult_i[1:0] == 2'b00);
    assign misaligned = (state_q == IDLE) & memOp & (ALUResult_i[1:0] != 2'b00);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        complete = 1'b0;
        abort    = 1'b0;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                if (alignedOp) begin
                    if (mem_ack_i) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = BUSY;
                        count_d = CW'(1);
                    end
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                    count_d  = '0;
                end else if (count_q == CW'(TIMEOUT - 1)) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    stall   = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // Request is gated by reset so it drops the instant reset asserts.
    assign mem_req_o   = ~rst_i & ((state_q == BUSY) | ((state_q == IDLE) & alignedOp));
    assign mem_we_o    = MemWrite_i;
    assign mem_addr_o  = {ALUResult_i[31:2], 2'b00};
    assign mem_wdata_o = RS2data_i;
    assign stall_o     = stall;
    assign pc_src_o    = Branch_i & Zero_i;
    assign pc_branch_o = pc_branch_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            count_q     <= '0;
            regWrite_q  <= 1'b0;
            memtoReg_q  <= 1'b0;
            aluResult_q <= '0;
            readData_q  <= '0;
            rdAddr_q    <= '0;
            err_q       <= 1'b0;
            errCause_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (stall) begin
                regWrite_q <= 1'b0;
                memtoReg_q <= 1'b0;
            end else begin
                regWrite_q  <= RegWrite_i & ~misaligned & ~abort;
                memtoReg_q  <= MemtoReg_i;
                aluResult_q <= ALUResult_i;
                rdAddr_q    <= RDaddr_i;
                if (misaligned | abort) begin
                    readData_q <= '0;
                end else if (isLoad & complete) begin
                    readData_q <= mem_rdata_i;
                end
            end
            // Sticky: the first error's cause is kept until reset.
            if (!err_q && (misaligned || abort)) begin
                err_q      <= 1'b1;
                errCause_q <= misaligned ? 2'b01 : 2'b10;
            end
        end
    end

    assign RegWrite_o  = regWrite_q;
    assign MemtoReg_o  = memtoReg_q;
    assign ALUResult_o = aluResult_q;
    assign ReadData_o  = readData_q;
    assign RDaddr_o    = rdAddr_q;
    assign err_o       = err_q;
    assign err_cause_o = errCause_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: table of instructions with a modelled memory
// ack delay, a writeback scoreboard, and hand-written reset/error sequences.
module tb_mem_access_stage;

    localparam int TIMEOUT = 16;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    typedef struct {
        logic        memRead, memWrite, memtoReg, regWrite, branch, zero;
        logic [4:0]  rd;
        logic [31:0] alu, rs2, target, rdata;
        int          waitN;
        int          expStalls;
        logic        expRegWrite;
        logic [31:0] expReadData;
        logic        expErr;
        logic [1:0]  expCause;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] ALUResult_i, RS2data_i, pc_branch_i, mem_rdata_i;
    logic        Zero_i, Branch_i, MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i, mem_ack_i;
    logic [4:0]  RDaddr_i;
    logic        mem_req_o, mem_we_o, stall_o, pc_src_o, RegWrite_o, MemtoReg_o, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, pc_branch_o, ALUResult_o, ReadData_o;
    logic [4:0]  RDaddr_o;
    logic [1:0]  err_cause_o;

    int   testsRun = 0;
    int   testsFailed = 0;
    vec_t vecs[11];
    vec_t expQ[$];

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ALUResult_i(ALUResult_i), .RS2data_i(RS2data_i), .Zero_i(Zero_i),
        .pc_branch_i(pc_branch_i), .Branch_i(Branch_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i),
        .RDaddr_i(RDaddr_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .pc_src_o(pc_src_o),
        .pc_branch_o(pc_branch_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
        .ALUResult_o(ALUResult_o), .ReadData_o(ReadData_o), .RDaddr_o(RDaddr_o),
        .err_o(err_o), .err_cause_o(err_cause_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        {MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i, Branch_i, Zero_i, mem_ack_i} = '0;
        RDaddr_i = '0;
        ALUResult_i = '0;
        RS2data_i = '0;
        pc_branch_i = '0;
        mem_rdata_i = '0;
    endtask

    // Called at posedge+1 once an instruction has left the stage.
    task automatic checkWriteback();
        vec_t e;
        if (expQ.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = expQ.pop_front();
        checkOutput("RegWrite_o", 32'(RegWrite_o), 32'(e.expRegWrite));
        checkOutput("MemtoReg_o", 32'(MemtoReg_o), 32'(e.memtoReg));
        checkOutput("ALUResult_o", ALUResult_o, e.alu);
        checkOutput("ReadData_o", ReadData_o, e.expReadData);
        checkOutput("RDaddr_o", 32'(RDaddr_o), 32'(e.rd));
        checkOutput("err_o", 32'(err_o), 32'(e.expErr));
        checkOutput("err_cause_o", 32'(err_cause_o), 32'(e.expCause));
    endtask

    // Entered at posedge+1; memory acks on cycle index waitN after issue.
    task automatic applyStimulus(input vec_t v);
        int   cyc = 0;
        int   stalls = 0;
        logic done = 1'b0;
        logic expReq;
        MemRead_i = v.memRead;   MemWrite_i = v.memWrite;
        MemtoReg_i = v.memtoReg; RegWrite_i = v.regWrite;
        Branch_i = v.branch;     Zero_i = v.zero;
        RDaddr_i = v.rd;         ALUResult_i = v.alu;
        RS2data_i = v.rs2;       pc_branch_i = v.target;
        mem_rdata_i = v.rdata;
        expReq = (v.memRead | v.memWrite) & (v.alu[1:0] == 2'b00);
        expQ.push_back(v);
        while (!done) begin
            mem_ack_i = (cyc == v.waitN);
            @(negedge clk_i);
            checkOutput("mem_req_o", 32'(mem_req_o), 32'(expReq));
            checkOutput("pc_src_o", 32'(pc_src_o), 32'(v.branch & v.zero));
            if (cyc == 0) begin
                checkOutput("pc_branch_o", pc_branch_o, v.target);
                if (expReq) begin
                    checkOutput("mem_we_o", 32'(mem_we_o), 32'(v.memWrite));
                    checkOutput("mem_addr_o", mem_addr_o, v.alu);
                    checkOutput("mem_wdata_o", mem_wdata_o, v.rs2);
                end
            end
            if (stall_o) stalls++;
            else done = 1'b1;
            @(posedge clk_i);
            #1;
            if (!done) begin
                if (stalls == 1) begin
                    checkOutput("bubble_RegWrite", 32'(RegWrite_o), 32'd0);
                    checkOutput("bubble_MemtoReg", 32'(MemtoReg_o), 32'd0);
                end
                cyc++;
                if (cyc > 40) begin
                    checkOutput("stall_cycle_bound", 32'(cyc), 32'd40);
                    done = 1'b1;
                end
            end
        end
        mem_ack_i = 1'b0;
        checkOutput("stall_cycles", 32'(stalls), 32'(v.expStalls));
        checkWriteback();
    endtask

    task automatic doReset();
        clearInputs();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("rst_mem_req_o", 32'(mem_req_o), 32'd0);
        checkOutput("rst_stall_o", 32'(stall_o), 32'd0);
        checkOutput("rst_wb_fields", {RegWrite_o, MemtoReg_o, RDaddr_o, err_o, err_cause_o},
                    32'd0);
        checkOutput("rst_ALUResult_o", ALUResult_o, 32'd0);
        checkOutput("rst_ReadData_o", ReadData_o, 32'd0);
        rst_i = 1'b0;
    endtask

    initial begin
        vec_t v;
        //          rd  wr  m2r rw  br  z   rd     alu          rs2          target      rdata        wait stl eRW eRdata      eErr eCause
        vecs[0]  = '{F, F, F, T, F, F, 5'd5,  32'h1234, 32'h0,    32'h0,   32'h0,    0,    0,  T, 32'h0,    F, 2'b00};
        vecs[1]  = '{T, F, T, T, F, F, 5'd6,  32'h40,   32'h0,    32'h0,   32'hCAFE, 0,    0,  T, 32'hCAFE, F, 2'b00};
        vecs[2]  = '{F, T, F, F, F, F, 5'd0,  32'h80,   32'hBEEF, 32'h0,   32'hDEAD, 3,    3,  F, 32'hCAFE, F, 2'b00};
        vecs[3]  = '{T, F, T, T, F, F, 5'd7,  32'h44,   32'h0,    32'h0,   32'h5A5A, 1,    1,  T, 32'h5A5A, F, 2'b00};
        vecs[4]  = '{F, F, F, F, T, T, 5'd0,  32'h0,    32'h0,    32'h100, 32'h1111, 0,    0,  F, 32'h5A5A, F, 2'b00};
        vecs[5]  = '{F, F, F, T, T, F, 5'd9,  32'h77,   32'h0,    32'h200, 32'h0,    0,    0,  T, 32'h5A5A, F, 2'b00};
        vecs[6]  = '{T, T, F, F, F, F, 5'd0,  32'h90,   32'h1357, 32'h0,   32'h2222, 2,    2,  F, 32'h5A5A, F, 2'b00};
        vecs[7]  = '{T, F, T, T, F, F, 5'd8,  32'hA0,   32'h0,    32'h0,   32'h0F0F, 15,   15, T, 32'h0F0F, F, 2'b00};
        vecs[8]  = '{T, F, F, T, F, F, 5'd3,  32'h42,   32'h0,    32'h0,   32'h3333, 0,    0,  F, 32'h0,    T, 2'b01};
        vecs[9]  = '{T, F, F, T, F, F, 5'd4,  32'h48,   32'h0,    32'h0,   32'h4444, 1000, 15, F, 32'h0,    T, 2'b01};
        vecs[10] = '{F, F, F, T, F, F, 5'd10, 32'hABC,  32'h0,    32'h0,   32'h0,    0,    0,  T, 32'h0,    T, 2'b01};

        clearInputs();
        rst_i = 1'b1;
        @(posedge clk_i);
        doReset();

        for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

        // Sticky error clears only on reset; timeout first then misaligned keeps 10.
        doReset();
        v = '{T, F, F, T, F, F, 5'd11, 32'h50, 32'h0, 32'h0, 32'h5555, 1000, 15, F, 32'h0, T, 2'b10};
        applyStimulus(v);
        v = '{F, T, F, F, F, F, 5'd0, 32'h61, 32'h9, 32'h0, 32'h0, 0, 0, F, 32'h0, T, 2'b10};
        applyStimulus(v);

        // Reset while a load is waiting in BUSY.
        MemRead_i = 1'b1;
        RegWrite_i = 1'b1;
        ALUResult_i = 32'h70;
        mem_ack_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #3;
        checkOutput("busy_stall_o", 32'(stall_o), 32'd1);
        rst_i = 1'b1;
        #1;
        checkOutput("async_rst_mem_req_o", 32'(mem_req_o), 32'd0);
        checkOutput("async_rst_err_o", 32'(err_o), 32'd0);
        @(negedge clk_i);
        clearInputs();
        rst_i = 1'b0;
        #1;
        checkOutput("post_rst_idle_req", 32'(mem_req_o), 32'd0);
        checkOutput("post_rst_idle_stall", 32'(stall_o), 32'd0);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
